frame_mean_div: RTL and testbench

Per-frame mean stage directly downstream of the skin-pixel accumulator (summator). It counts the skin pixels of a frame itself, from the same enable that drives the accumulator. At end of frame it waits for the accumulator pipeline to settle, then captures the 19-bit running sum and issues the accumulator clear. It then performs a sequential restoring division sum/count and presents the 10-bit mean coordinate with a one-cycle valid pulse.

---
 rtl/frame_mean_div.sv | 118 +++++++++++
 tb/tb_frame_mean_div.sv | 134 +++++++++++++
 2 files changed

// File: rtl/frame_mean_div.sv
// Per-frame mean of accumulated skin-pixel coordinates: waits for the accumulator to settle, then divides sum by count.
// mean_valid fires SETTLE+21 cycles after eof; there is no backpressure, and pixels or eof arriving while busy raise overrun.
module frame_mean_div #(
   parameter int SETTLE  = 4,
   parameter int CLR_LEN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_ce,
   input  logic        eof,
   input  logic [18:0] sum_in,
   output logic        acc_clr,
   output logic [9:0]  mean,
   output logic        mean_valid,
   output logic        div_zero,
   output logic        busy,
   output logic        overrun
);

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CAPT, S_DIV, S_DONE} state_t;

   localparam int CW = $clog2(CLR_LEN + 1);
   localparam logic [18:0] CNT_MAX = '1;

   state_t        state, nxt;
   logic [4:0]    step;
   logic [18:0]   count, divisor, quo, rem;
   logic [CW-1:0] clr_cnt;
   logic [19:0]   rem_sh, trial;
   logic [18:0]   rem_nx, quo_nx;

   // One restoring step: dividend bits leave quo at the top while quotient bits enter at the bottom.
   always_comb begin
      rem_sh = {rem, quo[18]};
      trial  = rem_sh - {1'b0, divisor};
      if (!trial[19]) begin
         rem_nx = trial[18:0];
         quo_nx = {quo[17:0], 1'b1};
      end else begin
         rem_nx = rem_sh[18:0];
         quo_nx = {quo[17:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:   if (eof) nxt = S_SETTLE;
         S_SETTLE: if (step == 5'(SETTLE - 1)) nxt = S_CAPT;
         S_CAPT:   nxt = S_DIV;
         S_DIV:    if (step == 5'd18) nxt = S_DONE;
         S_DONE:   nxt = S_IDLE;
         default:  nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != S_IDLE);
      mean_valid = (state == S_DONE);
   end

   assign acc_clr = (clr_cnt != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step     <= '0;
         count    <= '0;
         divisor  <= '0;
         quo      <= '0;
         rem      <= '0;
         clr_cnt  <= '0;
         mean     <= '0;
         div_zero <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         step <= (nxt != state) ? 5'd0 : step + 5'd1;

         if (state == S_IDLE && pix_ce && count != CNT_MAX)
            count <= count + 19'd1;
         if (state != S_IDLE && (pix_ce || eof))
            overrun <= 1'b1;

         // Clear is timed independently so it can run on into the division.
         if (state == S_SETTLE && nxt == S_CAPT)
            clr_cnt <= CW'(CLR_LEN);
         else if (clr_cnt != '0)
            clr_cnt <= clr_cnt - CW'(1);

         if (state == S_CAPT) begin
            quo     <= sum_in;
            divisor <= count;
            rem     <= '0;
            count   <= '0;
         end

         if (state == S_DIV) begin
            rem <= rem_nx;
            quo <= quo_nx;
            // Result lands on the last step so it is stable throughout the DONE cycle.
            if (step == 5'd18) begin
               if (divisor == '0) begin
                  mean     <= '0;
                  div_zero <= 1'b1;
               end else begin
                  mean     <= (quo_nx[18:10] != '0) ? 10'h3FF : quo_nx[9:0];
                  div_zero <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_mean_div.sv
// Directed bench for frame_mean_div: each frame is driven, then the 26 cycles after eof are traced and compared.
module tb_frame_mean_div;

   logic        clk;
   logic        rst;
   logic        pix_ce;
   logic        eof;
   logic [18:0] sum_in;
   logic        acc_clr;
   logic [9:0]  mean;
   logic        mean_valid;
   logic        div_zero;
   logic        busy;
   logic        overrun;

   int vec  = 0;
   int miss = 0;

   frame_mean_div #(.SETTLE(4), .CLR_LEN(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_ce     (pix_ce),
      .eof        (eof),
      .sum_in     (sum_in),
      .acc_clr    (acc_clr),
      .mean       (mean),
      .mean_valid (mean_valid),
      .div_zero   (div_zero),
      .busy       (busy),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed running required finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cycle n of the trace is the value seen just before the n-th rising edge after the eof edge.
   task automatic run_frame(input string tag, input logic [18:0] s, input int np, input bit pe_eof,
                            input int gap, input int inj_eof, input int inj_pix, input int rst_at,
                            input logic [9:0] em, input logic edz, input logic eov);
      logic [31:0] clr_seen, mv_seen, busy_seen, e_busy, e_mv;
      int hit;
      hit = 0;
      clr_seen = '0;
      mv_seen = '0;
      busy_seen = '0;
      sum_in = s;
      for (int i = 0; i < np - (pe_eof ? 1 : 0); i++) begin
         pix_ce = 1'b1;
         if (acc_clr) hit++;
         @(negedge clk);
      end
      pix_ce = 1'b0;
      repeat (gap) @(negedge clk);
      eof = 1'b1;
      pix_ce = pe_eof;
      if (pe_eof && acc_clr) hit++;
      for (int n = 1; n <= 26; n++) begin
         @(negedge clk);
         clr_seen[n]  = acc_clr;
         mv_seen[n]   = mean_valid;
         busy_seen[n] = busy;
         if (n == 25 && rst_at == 0)
            chk({tag, "_mean_at_valid"}, 32'(mean), 32'(em));
         eof    = (n == inj_eof);
         pix_ce = (n == inj_pix);
         if (n == rst_at) begin
            rst = 1'b0;
            #1;
            chk({tag, "_async_reset_outputs"},
                32'({acc_clr, mean, mean_valid, div_zero, busy, overrun}), 32'd0);
         end
         if (rst_at != 0 && n == rst_at + 2) rst = 1'b1;
      end
      e_busy = (rst_at != 0) ? ((32'd1 << (rst_at + 1)) - 32'd2) : 32'h03FF_FFFE;
      e_mv   = (rst_at != 0) ? 32'd0 : 32'h0200_0000;
      chk({tag, "_acc_clr_trace"}, clr_seen, 32'h0000_01E0);
      chk({tag, "_mean_valid_trace"}, mv_seen, e_mv);
      chk({tag, "_busy_trace"}, busy_seen, e_busy);
      chk({tag, "_mean_held"}, 32'(mean), 32'(em));
      chk({tag, "_div_zero"}, 32'(div_zero), 32'(edz));
      chk({tag, "_overrun"}, 32'(overrun), 32'(eov));
      chk({tag, "_clr_during_pixels"}, 32'(hit), 32'd0);
   endtask

   initial begin
      rst    = 1'b0;
      pix_ce = 1'b0;
      eof    = 1'b0;
      sum_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({acc_clr, mean, mean_valid, div_zero, busy, overrun}), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      run_frame("exact",      19'd100,    4,   1'b0, 0, 0,  0,  0,  10'd25,   1'b0, 1'b0);
      repeat (3) @(negedge clk);
      run_frame("trunc",      19'd4,      3,   1'b1, 0, 0,  0,  0,  10'd1,    1'b0, 1'b0);
      repeat (3) @(negedge clk);
      run_frame("max511",     19'd522753, 511, 1'b0, 0, 0,  0,  0,  10'd1023, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      run_frame("saturate",   19'd2048,   1,   1'b0, 0, 0,  0,  0,  10'd1023, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      run_frame("empty",      19'd0,      0,   1'b0, 0, 0,  0,  0,  10'd0,    1'b1, 1'b0);
      repeat (3) @(negedge clk);
      run_frame("overrun",    19'd60,     3,   1'b0, 0, 10, 12, 0,  10'd20,   1'b0, 1'b1);
      repeat (3) @(negedge clk);
      run_frame("after_ovr",  19'd40,     4,   1'b0, 0, 0,  0,  0,  10'd10,   1'b0, 1'b1);
      repeat (3) @(negedge clk);
      run_frame("rst_mid",    19'd100,    4,   1'b0, 0, 0,  0,  15, 10'd0,    1'b0, 1'b0);
      repeat (3) @(negedge clk);
      run_frame("fresh",      19'd30,     3,   1'b0, 0, 0,  0,  0,  10'd10,   1'b0, 1'b0);
      repeat (3) @(negedge clk);
      run_frame("b2b_a",      19'd900,    9,   1'b0, 0, 0,  0,  0,  10'd100,  1'b0, 1'b0);
      run_frame("b2b_b",      19'd1000,   5,   1'b0, 35, 0, 0,  0,  10'd200,  1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
